// File: rtl/seq_mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
// SEQ_MUL_SIGNED_EN is consumed by the interface, datapath and top.
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Iteration counter holds WIDTH-1 down to 0.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Handshake and operand bus of seq_multiplier.
// signed_mode exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_multiplier_if #(parameter int WIDTH = 16);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef SEQ_MUL_SIGNED_EN
  logic                 signed_mode;
`endif
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

`ifdef SEQ_MUL_SIGNED_EN
  modport master (output start, a, b, signed_mode, input ready, busy, done, result);
  modport slave  (input start, a, b, signed_mode, output ready, busy, done, result);
`else
  modport master (output start, a, b, input ready, busy, done, result);
  modport slave  (input start, a, b, output ready, busy, done, result);
`endif
endinterface

// File: rtl/seq_mul_datapath.sv
// Operand/accumulator registers and one radix-2 shift-add step per cycle.
// With SEQ_MUL_SIGNED_EN, magnitudes are multiplied and the product negated on sign mismatch.
module seq_mul_datapath #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic [2*WIDTH-1:0] prod
);
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, a_mag, b_mag;

`ifdef SEQ_MUL_SIGNED_EN
  logic a_neg, b_neg, neg;
  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];
  // -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       neg <= 1'b0;
    else if (load) neg <= a_neg ^ b_neg;
  end

  assign prod = neg ? (~acc_nxt + 1'b1) : acc_nxt;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign prod  = acc_nxt;
`endif

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier: IDLE/RUN/DONE control, WIDTH-cycle latency.
// Define SEQ_MUL_SIGNED_EN to add two's-complement support via signed_mode.
module seq_multiplier
  import seq_mul_pkg::*;
#(parameter int WIDTH = 16) (
  input logic              clk,
  input logic              rst,
  seq_multiplier_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;
  logic [2*WIDTH-1:0] prod;
  logic               accept;

  assign accept     = bus.start && (state != RUN);
  assign bus.ready  = (state != RUN);
  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  seq_mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .step        (state == RUN),
    .a           (bus.a),
    .b           (bus.b),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_mode (bus.signed_mode),
`endif
    .prod        (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= CW'(WIDTH-1);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Last iteration folds its partial product straight into result.
          if (cnt == '0) begin
            result_q <= prod;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=16).
// Signed vectors are included when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_multiplier;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  bit   rdy_low;
  bit   saw_done;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_mode = sm;
`else
    if (sm) bus.start = 1'b1;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges until done; drives ignored junk starts for the first 'noise' cycles.
  task automatic wait_done(input int noise, output int l, output bit rl);
    l  = -1;
    rl = 1'b1;
    for (int i = 1; i <= W + 4; i++) begin
      if (i <= noise) begin
        bus.start = 1'b1;
        bus.a     = 16'd2000;
        bus.b     = 16'd3000;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        l = i;
        break;
      end
      if (bus.ready || !bus.busy) rl = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready",  bus.ready,  1);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_done",   bus.done,   0);
    chk("rst_result", bus.result, 0);
    rst = 1'b0;

    // 100 x 50, accepted on first edge after reset release
    start_op(16'd100, 16'd50, 1'b0);
    wait_done(0, lat, rdy_low);
    chk("lat_100x50", lat, W);
    chk("res_100x50", bus.result, 5000);
    chk("ready_low_run", rdy_low, 1);
    @(posedge clk); @(negedge clk);
    chk("done_pulse_1cyc", bus.done, 0);
    chk("idle_ready", bus.ready, 1);

    // full-range unsigned
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(0, lat, rdy_low);
    chk("lat_max", lat, W);
    chk("res_max", bus.result, 64'd4294836225);
    repeat (3) @(negedge clk);
    chk("res_hold_idle", bus.result, 64'd4294836225);
    start_op(16'd12345, 16'd0, 1'b0);
    repeat (8) begin @(posedge clk); @(negedge clk); end
    chk("res_hold_run", bus.result, 64'd4294836225);
    wait_done(0, lat, rdy_low);
    chk("lat_x0", lat, W - 8);
    chk("res_x0", bus.result, 0);
    @(negedge clk);

    // starts during RUN ignored, then back-to-back start from DONE
    start_op(16'd77, 16'd88, 1'b0);
    wait_done(6, lat, rdy_low);
    chk("lat_77x88", lat, W);
    chk("res_77x88", bus.result, 6776);
    start_op(16'd88, 16'd77, 1'b0);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done_low", bus.done, 0);
    wait_done(0, lat, rdy_low);
    chk("lat_b2b", lat, W);
    chk("res_88x77", bus.result, 6776);
    @(negedge clk);

    // reset mid-RUN aborts
    start_op(16'd300, 16'd100, 1'b0);
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    chk("abort_result", bus.result, 0);
    chk("abort_ready",  bus.ready,  1);
    chk("abort_busy",   bus.busy,   0);
    saw_done = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (i == 1) rst = 1'b0;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_res_after", bus.result, 0);
    start_op(16'd123, 16'd456, 1'b0);
    wait_done(0, lat, rdy_low);
    chk("lat_123x456", lat, W);
    chk("res_123x456", bus.result, 56088);
    @(negedge clk);

`ifdef SEQ_MUL_SIGNED_EN
    start_op(16'hFFFD, 16'd5, 1'b1);
    wait_done(0, lat, rdy_low);
    chk("lat_s_m3x5", lat, W);
    chk("res_s_m3x5", bus.result, 64'hFFFFFFF1);
    @(negedge clk);
    start_op(16'h8000, 16'h8000, 1'b1);
    wait_done(0, lat, rdy_low);
    chk("res_s_min", bus.result, 64'h40000000);
    @(negedge clk);
    start_op(16'hFFFF, 16'd2, 1'b0);
    wait_done(0, lat, rdy_low);
    chk("res_u_ffffx2", bus.result, 131070);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
